// File: rtl/arbitro_mux_2in.sv
// arbitro_mux_2in: two-requester round-robin burst arbiter driving the Sel of a 16-bit 2:1 mux
// Optional feature macro: ARB_STATS_EN adds per-side transfer counters CuentaA/CuentaB.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   ReqA/AckA         requester A valid/ready (mux Sel=1 leg)
//   ReqB/AckB         requester B valid/ready (mux Sel=0 leg)
//   SalidaListo       downstream ready
//   SalidaValida      mux output valid towards downstream
//   Sel               registered mux select, 1=A 0=B
//   Ocupado           high while a grant is held
//   CuentaA/CuentaB   16-bit wrapping transfer counters (ARB_STATS_EN only)
module arbitro_mux_2in #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic ReqA,
    input  logic ReqB,
    output logic AckA,
    output logic AckB,
    input  logic SalidaListo,
    output logic SalidaValida,
    output logic Sel,
    output logic Ocupado
`ifdef ARB_STATS_EN
    ,
    output logic [15:0] CuentaA,
    output logic [15:0] CuentaB
`endif
);
    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
    state_t state, state_n, swap;
    logic ultimo;
    logic [CNT_W-1:0] rafaga, rafaga_n;
    logic grant_a, grant_b, mine, other, t, fin, enter;
    always_comb begin
        grant_a      = state == GRANT_A;
        grant_b      = state == GRANT_B;
        SalidaValida = !reset && ((grant_a && ReqA) || (grant_b && ReqB));
        AckA         = !reset && grant_a && SalidaListo;
        AckB         = !reset && grant_b && SalidaListo;
        Ocupado      = !reset && state != IDLE;
        t            = SalidaValida && SalidaListo;
        mine         = grant_a ? ReqA : ReqB;
        other        = grant_a ? ReqB : ReqA;
        fin          = rafaga == CNT_W'(MAX_BURST - 1);
        swap         = grant_a ? GRANT_B : GRANT_A;
    end
    // ultimo=1 means A owned last; on a tie in IDLE the other side wins
    always_comb begin
        state_n  = state;
        rafaga_n = rafaga;
        if (state == IDLE) begin
            if (ReqA || ReqB)
                state_n = (ReqA && (!ReqB || !ultimo)) ? GRANT_A : GRANT_B;
        end else if (!mine) begin
            state_n = other ? swap : IDLE;
        end else if (t) begin
            if (fin) begin
                state_n  = other ? swap : state;
                rafaga_n = '0;
            end else begin
                rafaga_n = rafaga + CNT_W'(1);
            end
        end
        enter = state_n != state && state_n != IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            Sel    <= 1'b0;
            ultimo <= 1'b0;
            rafaga <= '0;
        end else begin
            state  <= state_n;
            rafaga <= enter ? '0 : rafaga_n;
            if (enter) begin
                Sel    <= state_n == GRANT_A;
                ultimo <= state_n == GRANT_A;
            end
        end
    end
`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            CuentaA <= '0;
            CuentaB <= '0;
        end else begin
            if (ReqA && AckA) CuentaA <= CuentaA + 16'd1;
            if (ReqB && AckB) CuentaB <= CuentaB + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_arbitro_mux_2in.sv
// tb_arbitro_mux_2in: directed plus randomized checks of arbitro_mux_2in against a transfer-level model
module tb_arbitro_mux_2in;
    localparam int MAX_BURST = 4;
    logic clk = 1'b0;
    logic reset = 1'b1, ReqA = 1'b0, ReqB = 1'b0, SalidaListo = 1'b0;
    logic AckA, AckB, SalidaValida, Sel, Ocupado;
`ifdef ARB_STATS_EN
    logic [15:0] CuentaA, CuentaB;
`endif
    int passed = 0, total = 0;
    int own = 0;
    int n = 0;
    bit last_a = 1'b0, msel = 1'b0, known = 1'b0, xa, xb;
    int ca = 0, cb = 0;
    string tr = "";
    bit ra, rb, rr;

    arbitro_mux_2in #(.MAX_BURST(MAX_BURST), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .ReqA(ReqA), .ReqB(ReqB), .AckA(AckA), .AckB(AckB),
        .SalidaListo(SalidaListo), .SalidaValida(SalidaValida), .Sel(Sel), .Ocupado(Ocupado)
`ifdef ARB_STATS_EN
        , .CuentaA(CuentaA), .CuentaB(CuentaB)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chks(input string tag, input string obs, input string exp);
        total++;
        assert (obs == exp) passed++;
        else $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
    endtask

    task automatic grant(input bit to_a);
        own    = to_a ? 1 : 2;
        msel   = to_a;
        last_a = to_a;
        n      = 0;
    endtask

    task automatic step(input bit r, input bit a, input bit b, input bit l);
        bit ea, eb, ev, eo, mine, oth;
        @(negedge clk);
        reset = r; ReqA = a; ReqB = b; SalidaListo = l;
        #1;
        ea = !r && own == 1 && l;
        eb = !r && own == 2 && l;
        ev = !r && ((own == 1 && a) || (own == 2 && b));
        eo = !r && own != 0;
        chk("AckA", 32'(AckA), 32'(ea));
        chk("AckB", 32'(AckB), 32'(eb));
        chk("SalidaValida", 32'(SalidaValida), 32'(ev));
        chk("Ocupado", 32'(Ocupado), 32'(eo));
        if (known) chk("Sel", 32'(Sel), 32'(msel));
`ifdef ARB_STATS_EN
        if (known) begin
            chk("CuentaA", 32'(CuentaA), ca);
            chk("CuentaB", 32'(CuentaB), cb);
        end
`endif
        xa = a && ea;
        xb = b && eb;
        if (xa) begin tr = {tr, "A"}; ca = (ca + 1) % 65536; end
        if (xb) begin tr = {tr, "B"}; cb = (cb + 1) % 65536; end
        if (r) begin
            own = 0; msel = 1'b0; last_a = 1'b0; n = 0; ca = 0; cb = 0; known = 1'b1;
        end else if (own == 0) begin
            if (a || b) grant((a && b) ? !last_a : a);
        end else begin
            mine = (own == 1) ? a : b;
            oth  = (own == 1) ? b : a;
            if (!mine) begin
                if (oth) grant(own != 1);
                else own = 0;
            end else if (l) begin
                n++;
                if (n == MAX_BURST) begin
                    if (oth) grant(own != 1);
                    else n = 0;
                end
            end
        end
    endtask

    initial begin
        step(1, 1, 1, 1);
        step(1, 1, 1, 1);
        chk("reset_sel", 32'(Sel), 32'd0);
        step(0, 1, 1, 1);
        @(posedge clk); #1;
        chk("release_sel", 32'(Sel), 32'd1);
        chk("release_busy", 32'(Ocupado), 32'd1);
        tr = "";
        for (int i = 0; i < 12; i++) step(0, 1, 1, 1);
        chks("alternation", tr, "AAAABBBBAAAA");
        step(1, 0, 0, 1);
        step(0, 1, 0, 1);
        tr = "";
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        chks("pre_reset_burst", tr, "AA");
        step(1, 1, 1, 1);
        chks("reset_cycle_no_xfer", tr, "AA");
        step(0, 1, 1, 1);
        @(posedge clk); #1;
        chk("post_reset_grant_a", 32'(Sel), 32'd1);
        step(1, 0, 0, 1);
        tr = "";
        for (int i = 0; i < 6; i++) step(0, 1, 0, 1);
        chks("solo_a_wrap", tr, "AAAAA");
        tr = "";
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        chks("stall_no_xfer", tr, "");
        step(0, 1, 0, 1);
        chks("stall_resume", tr, "A");
        ra = 1'b0; rb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rr = $urandom_range(0, 99) == 0;
            step(rr, ra, rb, $urandom_range(0, 3) != 0);
            if (xa) ra = $urandom_range(0, 1) == 1;
            else if (!ra) ra = $urandom_range(0, 2) == 0;
            if (xb) rb = $urandom_range(0, 1) == 1;
            else if (!rb) rb = $urandom_range(0, 2) == 0;
        end
`ifdef ARB_STATS_EN
        step(1, 0, 0, 1);
        for (int i = 0; i < 70001; i++) step(0, 1, 0, 1);
        @(posedge clk); #1;
        chk("stats_a_wrap", 32'(CuentaA), 32'd4464);
        chk("stats_b_zero", 32'(CuentaB), 32'd0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
